// File: rtl/spi_master.sv
// SPI initiator for the register-file slave: turns one parallel command into a
// SYNC pulse followed by an N-pulse frame, and returns the read word in parallel.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | SCLK low, SCEB high, waiting for start
// S_SYNC  | one SCLK pulse with SCEB high to reset the slave bit counter
// S_SHIFT | SCEB low, N SCLK pulses, MOSI = frame bit, MISO sampled on rise
// S_DONE  | one cycle: SCEB high, done pulse, rdata update if read
module spi_master #(
  parameter int REGISTERS = 8,
  parameter int INPUTS    = 6,
  parameter int SWORD     = 8,
  parameter int CLKDIV    = 2,
  localparam int ADDRW    = $clog2((REGISTERS > INPUTS) ? REGISTERS : INPUTS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             wr,
  input  logic             rd,
  input  logic [ADDRW-1:0] addr,
  input  logic [SWORD-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [SWORD-1:0] rdata,
  output logic             SCEB,
  output logic             SCLK,
  output logic             MOSI,
  input  logic             MISO
);

  localparam int H  = 2 + ADDRW + SWORD;
  localparam int N  = H + SWORD + 1;
  localparam int PW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_SHIFT, S_DONE} state_t;

  state_t           state;
  logic [PW-1:0]    ph;
  logic             hi;
  logic [BW-1:0]    bitc;
  logic [N-1:0]     shreg;
  logic [SWORD-1:0] rx;
  logic             rd_lat;
  logic             phase_end;
  logic             in_window;
  logic             last_bit;

  assign phase_end = (ph == PW'(CLKDIV - 1));
  assign in_window = (bitc >= BW'(H + 1)) && (bitc <= BW'(H + SWORD));
  assign last_bit  = (bitc == BW'(N - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= S_IDLE;
      ph     <= '0;
      hi     <= 1'b0;
      bitc   <= '0;
      shreg  <= '0;
      rx     <= '0;
      rd_lat <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      rdata  <= '0;
      SCEB   <= 1'b1;
      SCLK   <= 1'b0;
      MOSI   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            shreg  <= {wr, rd, addr, wdata, {(SWORD + 1){1'b0}}};
            rd_lat <= rd;
            ph     <= '0;
            hi     <= 1'b0;
            busy   <= 1'b1;
            state  <= S_SYNC;
          end
        end
        S_SYNC, S_SHIFT: begin
          if (!phase_end) begin
            ph <= ph + 1'b1;
          end else begin
            ph <= '0;
            if (!hi) begin
              hi   <= 1'b1;
              SCLK <= 1'b1;
              if (state == S_SHIFT && in_window) rx <= {rx[SWORD-2:0], MISO};
            end else begin
              hi   <= 1'b0;
              SCLK <= 1'b0;
              // End of a high phase: either close the frame or start the next low phase.
              if (state == S_SHIFT && last_bit) begin
                state <= S_DONE;
                SCEB  <= 1'b1;
                MOSI  <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b1;
                if (rd_lat) rdata <= rx;
              end else begin
                SCEB  <= 1'b0;
                MOSI  <= shreg[N-1];
                shreg <= {shreg[N-2:0], 1'b0};
                bitc  <= (state == S_SYNC) ? '0 : bitc + 1'b1;
                state <= S_SHIFT;
              end
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: behavioural SPI slave on the pins plus a reference
// register/input model updated per command, with directed and random frames.
module tb_spi_master;

  localparam int REGISTERS = 8;
  localparam int INPUTS    = 6;
  localparam int SWORD     = 8;
  localparam int CLKDIV    = 2;
  localparam int ADDRW     = 3;
  localparam int H         = 2 + ADDRW + SWORD;
  localparam int N         = H + SWORD + 1;
  localparam int LATENCY   = 1 + 2 * CLKDIV * (N + 1);
  localparam int BUSYCYC   = 2 * CLKDIV * (N + 1);

  logic             CLK = 1'b0;
  logic             RST;
  logic             start;
  logic             wr_i;
  logic             rd_i;
  logic [ADDRW-1:0] addr_i;
  logic [SWORD-1:0] wdata_i;
  logic             busy;
  logic             done;
  logic [SWORD-1:0] rdata;
  logic             SCEB;
  logic             SCLK;
  logic             MOSI;
  logic             MISO = 1'b0;

  int checks   = 0;
  int failures = 0;

  spi_master #(
    .REGISTERS(REGISTERS), .INPUTS(INPUTS), .SWORD(SWORD), .CLKDIV(CLKDIV)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .wr(wr_i), .rd(rd_i), .addr(addr_i),
    .wdata(wdata_i), .busy(busy), .done(done), .rdata(rdata), .SCEB(SCEB),
    .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 CLK = ~CLK;

  // Behavioural slave: bit counter clocked only by SCLK, reset by a pulse with SCEB high.
  logic [SWORD-1:0] sR  [REGISTERS];
  logic [SWORD-1:0] sRD [INPUTS];
  int               cnt = 0;
  int               rises = 0;
  int               sync_rises = 0;
  logic [N-1:0]     cap = '0;
  logic [SWORD-1:0] rval = '0;

  function automatic logic [SWORD-1:0] slave_input(input int a);
    if (a == 2) return sR[2];
    if (a < INPUTS) return sRD[a];
    return '0;
  endfunction

  always @(posedge SCLK) begin
    rises = rises + 1;
    if (SCEB) begin
      cnt = 0;
      sync_rises = sync_rises + 1;
    end else begin
      if (cnt < N) cap[N-1-cnt] = MOSI;
      cnt = cnt + 1;
      if (cnt == 2 + ADDRW) rval = slave_input(int'(cap[N-3 -: ADDRW]));
      if (cnt == H && cap[N-1] && int'(cap[N-3 -: ADDRW]) < REGISTERS)
        sR[cap[N-3 -: ADDRW]] = cap[N-3-ADDRW -: SWORD];
    end
  end

  always @(negedge SCLK) begin
    if (cnt >= H + 1 && cnt <= H + SWORD) MISO = rval[SWORD-1-(cnt-H-1)];
    else MISO = 1'($urandom_range(0, 1));
  end

  // Reference model: what the slave should hold after each command.
  logic [SWORD-1:0] mR  [REGISTERS];
  logic [SWORD-1:0] mRD [INPUTS];
  logic [SWORD-1:0] exp_rdata = '0;

  function automatic logic [SWORD-1:0] ref_input(input int a);
    if (a == 2) return mR[2];
    if (a < INPUTS) return mRD[a];
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_input(input int a, input logic [SWORD-1:0] v);
    sRD[a] = v;
    mRD[a] = v;
  endtask

  task automatic run_frame(input logic w, input logic r, input logic [ADDRW-1:0] a,
                           input logic [SWORD-1:0] d, input bit poke);
    longint exp_frame;
    int n, nbusy;
    bit got;
    @(negedge CLK);
    chk("done_low_before", done, 0);
    rises = 0; sync_rises = 0; cap = '0;
    exp_frame = (longint'(w) << (N - 1)) | (longint'(r) << (N - 2)) |
                (longint'(a) << (N - 2 - ADDRW)) | (longint'(d) << (N - 2 - ADDRW - SWORD));
    if (r) exp_rdata = ref_input(int'(a));
    if (w && int'(a) < REGISTERS) mR[a] = d;
    wr_i = w; rd_i = r; addr_i = a; wdata_i = d; start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    wr_i = 1'($urandom); rd_i = 1'($urandom); addr_i = ADDRW'($urandom); wdata_i = SWORD'($urandom);
    n = 0; nbusy = 0; got = 0;
    while (!got && n < 400) begin
      @(negedge CLK);
      n++;
      if (busy) nbusy++;
      if (done) got = 1;
      if (poke && n == 10) begin
        start = 1'b1; wr_i = ~w; rd_i = ~r; addr_i = ~a; wdata_i = ~d;
      end else start = 1'b0;
    end
    chk("done_seen", got, 1);
    chk("latency", n, LATENCY);
    chk("busy_cycles", nbusy, BUSYCYC);
    chk("busy_low_at_done", busy, 0);
    chk("sceb_high_at_done", SCEB, 1);
    chk("rdata", rdata, exp_rdata);
    chk("frame_bits", cap, exp_frame[N-1:0]);
    chk("sclk_pulses", rises, N + 1);
    chk("sync_pulses", sync_rises, 1);
    for (int i = 0; i < REGISTERS; i++) chk($sformatf("slave_R%0d", i), sR[i], mR[i]);
  endtask

  initial begin
    int k;
    bit bad;
    RST = 1'b0; start = 1'b0; wr_i = 1'b0; rd_i = 1'b0; addr_i = '0; wdata_i = '0;
    for (int i = 0; i < REGISTERS; i++) begin sR[i] = '0; mR[i] = '0; end
    for (int i = 0; i < INPUTS; i++) set_input(i, SWORD'($urandom));
    set_input(3, 8'h3C);

    // Reset, then idle with no start.
    repeat (3) @(negedge CLK);
    chk("rst_sceb", SCEB, 1);
    chk("rst_busy", busy, 0);
    rises = 0;
    RST = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (SCEB !== 1'b1 || SCLK !== 1'b0 || MOSI !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
        bad = 1;
    end
    chk("idle_outputs_stable", bad, 0);
    chk("idle_sclk", SCLK, 0);
    chk("idle_mosi", MOSI, 0);
    chk("idle_done", done, 0);
    chk("idle_rdata", rdata, 0);
    chk("idle_no_sclk_edges", rises, 0);

    // Write R[5]=0xA5.
    run_frame(1'b1, 1'b0, 3'd5, 8'hA5, 0);
    chk("mosi_bits_0_12", cap[N-1 -: H], 13'b1010110100101);

    // Read RD[3]=0x3C.
    run_frame(1'b0, 1'b1, 3'd3, 8'h00, 0);

    // Read-modify on the register tied back to its own input.
    run_frame(1'b1, 1'b0, 3'd2, 8'h11, 0);
    run_frame(1'b1, 1'b1, 3'd2, 8'h77, 0);
    run_frame(1'b0, 1'b1, 3'd2, 8'h00, 0);

    // Start pulse mid-frame must be ignored.
    run_frame(1'b1, 1'b1, 3'd6, 8'h5A, 1);

    // Reset mid-frame at bit 7 of a read.
    @(negedge CLK);
    rises = 0; sync_rises = 0;
    wr_i = 1'b0; rd_i = 1'b1; addr_i = 3'd3; wdata_i = 8'h00; start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    k = 0;
    while (!(sync_rises == 1 && cnt == 7) && k < 400) begin
      @(negedge CLK);
      k++;
    end
    chk("reached_bit7", k < 400, 1);
    RST = 1'b0;
    #1;
    exp_rdata = '0;
    chk("abort_sceb", SCEB, 1);
    chk("abort_sclk", SCLK, 0);
    chk("abort_mosi", MOSI, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rdata", rdata, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    run_frame(1'b0, 1'b1, 3'd3, 8'h00, 0);

    // Random commands, including no-op frames and unpopulated input addresses.
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) set_input($urandom_range(0, INPUTS - 1), SWORD'($urandom));
      run_frame(1'($urandom), 1'($urandom), ADDRW'($urandom), SWORD'($urandom), 0);
    end
    run_frame(1'b0, 1'b0, 3'd1, 8'hFF, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
